// File: rtl/dds_phase_sine.sv
// DDS output stage: phase accumulator with phase-coherent FTW switching,
// followed by a two-stage quarter-wave sine lookup producing signed samples.
module dds_phase_sine #(
   parameter int PHASE_W = 16,
   parameter int ADDR_W  = 8,
   parameter int AMP_W   = 12
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               EN,
   input  logic [PHASE_W-1:0] FTW_IN,
   input  logic               FTW_VALID,
   output logic               FTW_READY,
   input  logic [PHASE_W-1:0] PHASE_OFS,
   input  logic               SYNC,
   output logic [PHASE_W-1:0] PHASE_OUT,
   output logic [AMP_W-1:0]   OUT,
   output logic               OUT_VALID
);

   localparam int     Q      = 2**(ADDR_W-2);
   localparam int     MW     = AMP_W-1;
   localparam int     STAGES = 2;
   localparam int     FX     = 30;
   localparam longint AMP    = (64'sd1 <<< (AMP_W-1)) - 64'sd1;

   // Fixed-point Taylor series so the table is a pure elaboration-time constant.
   function automatic logic [Q*MW-1:0] build_rom();
      logic [Q*MW-1:0] rom;
      longint pi_fx, one, x, x2, term, acc, m;
      rom   = '0;
      one   = 64'sd1 <<< FX;
      pi_fx = 64'sd3373259426;
      for (int i = 0; i < Q; i++) begin
         x    = (pi_fx * longint'(2*i+1) + longint'(2*Q)) / longint'(4*Q);
         x2   = (x * x) >>> FX;
         term = x;
         acc  = x;
         for (int k = 1; k < 10; k++) begin
            term = -(((term * x2) >>> FX) / longint'((2*k)*(2*k+1)));
            acc  = acc + term;
         end
         m = (AMP * acc + (one >>> 1)) >>> FX;
         if (m > AMP) m = AMP;
         rom[i*MW +: MW] = m[MW-1:0];
      end
      return rom;
   endfunction

   localparam logic [Q*MW-1:0] ROM = build_rom();

   logic [PHASE_W-1:0]  phase, ftw_act, ftw_pend;
   logic                pending;
   logic [STAGES:0]     vld_pipe;
   logic [MW-1:0]       mag1;
   logic                sign1;
   logic [AMP_W-1:0]    out_r;

   logic [PHASE_W:0]    acc_sum;
   logic                accept, apply;
   logic [ADDR_W-1:0]   p;
   logic [1:0]          quad;
   logic [ADDR_W-3:0]   idx, addr;
   logic [MW-1:0]       rom_mag;
   logic signed [AMP_W-1:0] smag;

   assign acc_sum = {1'b0, phase} + {1'b0, ftw_act};
   assign accept  = FTW_VALID & ~pending;
   // Accept cycle cannot apply: pending is still low then.
   assign apply   = pending & ((ftw_act == '0) | SYNC | (EN & acc_sum[PHASE_W]));

   assign p       = ADDR_W'((phase + PHASE_OFS) >> (PHASE_W-ADDR_W));
   assign quad    = p[ADDR_W-1:ADDR_W-2];
   assign idx     = p[ADDR_W-3:0];
   assign addr    = quad[0] ? ~idx : idx;
   assign rom_mag = ROM[addr*MW +: MW];
   assign smag    = {1'b0, mag1};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         phase    <= '0;
         ftw_act  <= '0;
         ftw_pend <= '0;
         pending  <= 1'b0;
         vld_pipe <= '0;
         mag1     <= '0;
         sign1    <= 1'b0;
         out_r    <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:0], EN};
         if (SYNC)
            phase <= '0;
         else if (EN)
            phase <= acc_sum[PHASE_W-1:0];
         if (apply) begin
            ftw_act <= ftw_pend;
            pending <= 1'b0;
         end else if (accept) begin
            ftw_pend <= FTW_IN;
            pending  <= 1'b1;
         end
         mag1  <= rom_mag;
         sign1 <= quad[1];
         if (vld_pipe[1])
            out_r <= sign1 ? -smag : smag;
      end
   end

   assign FTW_READY = ~pending;
   assign PHASE_OUT = phase;
   assign OUT       = out_r;
   assign OUT_VALID = vld_pipe[STAGES];

endmodule

// File: tb/tb_dds_phase_sine.sv
// Directed and random stimulus for dds_phase_sine against a sine/phase reference model.
module tb_dds_phase_sine;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1, EN = 1'b0, FTW_VALID = 1'b0, SYNC = 1'b0;
   logic [15:0] FTW_IN = '0, PHASE_OFS = '0;
   logic        FTW_READY, OUT_VALID;
   logic [15:0] PHASE_OUT;
   logic [11:0] OUT;

   int vectors = 0, miscompares = 0;

   int m_phase = 0, m_act = 0, m_pend = 0, m_out = 0;
   bit m_pending = 0, m_ovalid = 0, s1_v = 0, en_prev = 0;
   int s1_val = 0;
   int ph_hist[$];
   int out_by_phase[256];
   bit rec = 0;

   dds_phase_sine dut (
      .CLK(CLK), .RESET(RESET), .EN(EN), .FTW_IN(FTW_IN), .FTW_VALID(FTW_VALID),
      .FTW_READY(FTW_READY), .PHASE_OFS(PHASE_OFS), .SYNC(SYNC),
      .PHASE_OUT(PHASE_OUT), .OUT(OUT), .OUT_VALID(OUT_VALID)
   );

   always #5 CLK = ~CLK;

   // Ideal sine sampled at the centre of each 256-step phase bin.
   function automatic int ref_sample(int ph);
      int  pb, mag;
      real ang, s;
      pb  = (ph & 32'hFFFF) >> 8;
      ang = 2.0 * 3.141592653589793 * (real'(pb) + 0.5) / 256.0;
      s   = $sin(ang);
      mag = $rtoi(2047.0 * ((s < 0.0) ? -s : s) + 0.5);
      return (s < 0.0) ? -mag : mag;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input bit en, input bit sync, input bit fv, input logic [15:0] ftw, input bit rst);
      bit wrap, apl, acc;
      EN = en; SYNC = sync; FTW_VALID = fv; FTW_IN = ftw; RESET = rst;
      if (rst) begin
         m_phase = 0; m_act = 0; m_pend = 0; m_pending = 0;
         s1_v = 0; s1_val = 0; en_prev = 0; m_out = 0; m_ovalid = 0;
      end else begin
         wrap = en && (m_phase + m_act > 65535);
         apl  = m_pending && (m_act == 0 || sync || wrap);
         acc  = fv && !m_pending;
         if (s1_v) m_out = s1_val;
         m_ovalid = s1_v;
         s1_v     = en_prev;
         s1_val   = ref_sample(m_phase + int'(PHASE_OFS));
         en_prev  = en;
         if (sync)    m_phase = 0;
         else if (en) m_phase = (m_phase + m_act) % 65536;
         if (apl) begin
            m_act = m_pend; m_pending = 0;
         end else if (acc) begin
            m_pend = int'(ftw); m_pending = 1;
         end
      end
      ph_hist.push_back(m_phase);
      @(posedge CLK);
      #1;
      chk("phase", int'(PHASE_OUT), m_phase);
      chk("ready", int'(FTW_READY), int'(!m_pending));
      chk("out_valid", int'(OUT_VALID), int'(m_ovalid));
      chk("out", int'($signed(OUT)), m_out);
      if (rec && m_ovalid && ph_hist.size() >= 3)
         out_by_phase[ph_hist[ph_hist.size()-3] >> 8] = int'($signed(OUT));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 16'h0, 0);
   endtask

   initial begin
      int sum;
      for (int i = 0; i < 256; i++) out_by_phase[i] = 99999;

      // reset state
      step(0, 0, 0, 16'h0, 1);
      step(0, 0, 0, 16'h0, 1);

      // T1: load 0x0100 from idle, first sample
      step(1, 0, 1, 16'h0100, 0);
      chk("t1_ready_low", int'(FTW_READY), 0);
      step(1, 0, 0, 16'h0, 0);
      chk("t1_ready_back", int'(FTW_READY), 1);
      step(1, 0, 0, 16'h0, 0);
      chk("t1_first_out", int'($signed(OUT)), 25);
      run(4);
      chk("t1_phase", int'(PHASE_OUT), 16'h0500);

      // T2: full-period sweep, quadrant symmetry
      rec = 1;
      run(262);
      rec = 0;
      chk("t2_3F00", out_by_phase[8'h3F], 2047);
      chk("t2_4000", out_by_phase[8'h40], 2047);
      chk("t2_7F00", out_by_phase[8'h7F], 25);
      chk("t2_8000", out_by_phase[8'h80], -25);
      chk("t2_BF00", out_by_phase[8'hBF], -2047);
      chk("t2_FF00", out_by_phase[8'hFF], -25);
      chk("t2_0000", out_by_phase[8'h00], 25);
      sum = 0;
      for (int i = 0; i < 256; i++) sum += out_by_phase[i];
      chk("t2_sum", sum, 0);

      // T3: coherent switch at wrap, second offer ignored
      step(0, 0, 0, 16'h0, 1);
      step(1, 0, 1, 16'h4000, 0);
      step(1, 0, 0, 16'h0, 0);
      step(1, 0, 0, 16'h0, 0);
      chk("t3_start", int'(PHASE_OUT), 16'h4000);
      step(1, 0, 1, 16'h2000, 0);
      step(1, 0, 1, 16'h3000, 0);
      chk("t3_c000", int'(PHASE_OUT), 16'hC000);
      step(1, 0, 0, 16'h0, 0);
      chk("t3_wrap", int'(PHASE_OUT), 16'h0000);
      step(1, 0, 0, 16'h0, 0);
      chk("t3_ready", int'(FTW_READY), 1);
      step(1, 0, 0, 16'h0, 0);
      chk("t3_4000", int'(PHASE_OUT), 16'h4000);

      // T4: SYNC with pending FTW, then SYNC on a wrap cycle
      step(0, 0, 0, 16'h0, 1);
      step(1, 0, 1, 16'h0100, 0);
      step(1, 0, 0, 16'h0, 0);
      run(8'h72);
      step(1, 0, 1, 16'h0300, 0);
      chk("t4_7300", int'(PHASE_OUT), 16'h7300);
      step(1, 1, 0, 16'h0, 0);
      chk("t4_sync", int'(PHASE_OUT), 0);
      step(1, 0, 0, 16'h0, 0);
      chk("t4_inc", int'(PHASE_OUT), 16'h0300);
      step(0, 0, 0, 16'h0, 1);
      step(1, 0, 1, 16'h4000, 0);
      step(1, 0, 0, 16'h0, 0);
      step(1, 0, 0, 16'h0, 0);
      step(1, 0, 1, 16'h1000, 0);
      step(1, 0, 0, 16'h0, 0);
      step(1, 1, 0, 16'h0, 0);
      step(1, 0, 0, 16'h0, 0);
      chk("t4_wrap_sync", int'(PHASE_OUT), 16'h1000);

      // T5: reset mid-run with pending FTW
      step(1, 0, 1, 16'h0800, 0);
      step(1, 0, 0, 16'h0, 1);
      step(1, 0, 0, 16'h0, 0);
      chk("t5_valid", int'(OUT_VALID), 0);
      step(1, 0, 0, 16'h0, 0);
      chk("t5_phase", int'(PHASE_OUT), 0);

      // T6: EN toggling
      step(1, 0, 1, 16'h0100, 0);
      run(4);
      step(0, 0, 0, 16'h0, 0);
      step(0, 0, 0, 16'h0, 0);
      step(1, 0, 0, 16'h0, 0);
      step(1, 0, 0, 16'h0, 0);
      chk("t6_valid_low", int'(OUT_VALID), 0);
      run(3);

      // random traffic
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 31) == 0) PHASE_OFS = 16'($urandom);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 2) == 0,
              ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom),
              $urandom_range(0, 49) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
